pc_unit: RTL and testbench

- Program-counter and fetch-request stage of the RV32 core.
- Sits directly downstream of the branch judge. It consumes the judge's taken/not-taken result together with the branch operands, computes the redirect target and updates the PC.
- Issues sequential fetch requests to instruction fetch.
- On a redirect, pulses a flush that kills wrong-path instructions in IF/ID.

---
 rtl/pc_pkg.sv | 13 +
 rtl/branch_target.sv | 18 +
 rtl/pc_unit.sv | 64 ++++++
 tb/tb_pc_unit.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// pc_pkg: shared types and constants for the program-counter stage.
package pc_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    localparam int          INSN_BYTES       = 4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/branch_target.sv
// branch_target: combinational redirect target and alignment check.
module branch_target (
    input  logic        br_jalr,
    input  logic [31:0] br_pc,
    input  logic [31:0] br_imm,
    input  logic [31:0] rs1data,
    output logic [31:0] target,
    output logic        tgt_mis
);

    logic [31:0] sum;

    assign sum     = (br_jalr ? rs1data : br_pc) + br_imm;
    // jalr drops bit 0 first, so only bit 1 can still trip the check for it
    assign target  = br_jalr ? {sum[31:1], 1'b0} : sum;
    assign tgt_mis = |target[1:0];

endmodule

// File: rtl/pc_unit.sv
// pc_unit: PC register, fetch-request FSM and redirect/flush pulses.
module pc_unit
    import pc_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            br_valid,
    input  logic            br_taken,
    input  logic            br_jalr,
    input  logic [XLEN-1:0] br_pc,
    input  logic [XLEN-1:0] br_imm,
    input  logic [XLEN-1:0] rs1data,
    input  logic            stall,
    input  logic            if_ready,
    output logic            if_valid,
    output logic [XLEN-1:0] if_pc,
    output logic            flush,
    output logic            misalign,
    output logic            halted
);

    state_t          state, nstate;
    logic [XLEN-1:0] pc, target;
    logic            tgt_mis, acc, redir;

    branch_target u_tgt (
        .br_jalr (br_jalr),
        .br_pc   (br_pc),
        .br_imm  (br_imm),
        .rs1data (rs1data),
        .target  (target),
        .tgt_mis (tgt_mis)
    );

    assign if_pc = pc;
    assign acc   = if_valid & if_ready;
    assign redir = br_valid & br_taken & (state == RUN);

    always_comb begin
        if_valid = (state == RUN) & ~stall;
        nstate   = (state == BOOT) ? RUN : (redir & tgt_mis) ? HALT : state;
    end

    // a redirect overrides any same-cycle accept; that fetch is killed by flush
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= BOOT;
            pc       <= RESET_PC;
            flush    <= 1'b0;
            misalign <= 1'b0;
            halted   <= 1'b0;
        end else begin
            state    <= nstate;
            pc       <= redir ? (tgt_mis ? pc : target) : acc ? pc + XLEN'(INSN_BYTES) : pc;
            flush    <= redir;
            misalign <= redir & tgt_mis;
            halted   <= nstate == HALT;
        end
    end

endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed and random checks of pc_unit against a behavioural model.
module tb_pc_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        br_valid, br_taken, br_jalr, stall, if_ready;
    logic [31:0] br_pc, br_imm, rs1data;
    logic        if_valid, flush, misalign, halted;
    logic [31:0] if_pc;

    int checks = 0;
    int failures = 0;

    logic [31:0] m_pc;
    bit          m_run, m_halt, m_flush, m_mis;

    always #5 clk = ~clk;

    pc_unit #(.RESET_PC(32'h0)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .br_valid (br_valid),
        .br_taken (br_taken),
        .br_jalr  (br_jalr),
        .br_pc    (br_pc),
        .br_imm   (br_imm),
        .rs1data  (rs1data),
        .stall    (stall),
        .if_ready (if_ready),
        .if_valid (if_valid),
        .if_pc    (if_pc),
        .flush    (flush),
        .misalign (misalign),
        .halted   (halted)
    );

    function automatic bit exp_valid();
        return m_run && !m_halt && !stall;
    endfunction

    function automatic void model_reset();
        m_pc = 32'h0; m_run = 0; m_halt = 0; m_flush = 0; m_mis = 0;
    endfunction

    task automatic drive(input bit bv, bt, bj, input logic [31:0] bpc, bimm, rs1, input bit st, rdy);
        br_valid = bv; br_taken = bt; br_jalr = bj;
        br_pc = bpc; br_imm = bimm; rs1data = rs1;
        stall = st; if_ready = rdy;
        #1;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 1);
    endtask

    // model: one clock edge worth of architectural effect from the present inputs
    task automatic tick();
        logic [31:0] tgt;
        bit tk, acc;
        tgt = br_jalr ? ((rs1data + br_imm) & 32'hFFFF_FFFE) : (br_pc + br_imm);
        tk  = br_valid && br_taken && m_run && !m_halt;
        acc = exp_valid() && if_ready;
        m_flush = tk;
        m_mis   = tk && (tgt % 4 != 0);
        if (m_mis) m_halt = 1;
        else if (tk) m_pc = tgt;
        else if (acc) m_pc = m_pc + 4;
        m_run = 1;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        #2;
        rst_n = 1'b1;
    endtask

    task automatic jump_to(input logic [31:0] t);
        drive(1, 1, 0, t - 32'h10, 32'h10, 0, 0, 1);
        tick();
    endtask

    task automatic test_reset();
        idle();
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if ({if_valid, flush, misalign, halted, if_pc} !== 36'h0) begin
            failures++;
            $display("FAIL reset_state got v=%b f=%b m=%b h=%b pc=%h exp all zero", if_valid, flush, misalign, halted, if_pc);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (if_valid !== 1'b0) begin
            failures++;
            $display("FAIL boot_idle if_valid got %b exp 0", if_valid);
        end
        tick();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (if_pc !== 32'(i * 4) || if_valid !== 1'b1) begin
                failures++;
                $display("FAIL seq_fetch%0d got pc=%h v=%b exp pc=%h v=1", i, if_pc, if_valid, 32'(i * 4));
            end
            tick();
        end
    endtask

    task automatic test_redirect_acc();
        jump_to(32'h100);
        drive(1, 1, 0, 32'hF8, 32'h40, 0, 0, 1);
        checks++;
        if (if_pc !== 32'h100 || if_valid !== 1'b1) begin
            failures++;
            $display("FAIL redir_setup got pc=%h v=%b exp pc=00000100 v=1", if_pc, if_valid);
        end
        tick();
        idle();
        checks++;
        if ({if_pc, flush, misalign} !== {32'h138, 2'b10}) begin
            failures++;
            $display("FAIL redir_acc got pc=%h f=%b m=%b exp pc=00000138 f=1 m=0", if_pc, flush, misalign);
        end
        tick();
        checks++;
        if ({if_pc, flush} !== {32'h13C, 1'b0}) begin
            failures++;
            $display("FAIL redir_after got pc=%h f=%b exp pc=0000013c f=0", if_pc, flush);
        end
    endtask

    task automatic test_stall();
        jump_to(32'h40);
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 0, 0, 0, 1, 1);
            checks++;
            if (if_valid !== 1'b0 || if_pc !== 32'h40) begin
                failures++;
                $display("FAIL stall_hold%0d got v=%b pc=%h exp v=0 pc=00000040", i, if_valid, if_pc);
            end
            tick();
        end
        drive(1, 1, 0, 32'h40, 32'h40, 0, 1, 1);
        tick();
        checks++;
        if ({if_pc, flush, if_valid} !== {32'h80, 2'b10}) begin
            failures++;
            $display("FAIL stall_redir got pc=%h f=%b v=%b exp pc=00000080 f=1 v=0", if_pc, flush, if_valid);
        end
    endtask

    task automatic test_not_taken();
        logic [31:0] p;
        idle();
        tick();
        for (int i = 0; i < 3; i++) begin
            p = if_pc;
            drive(1, 0, i[0], 32'h80, 32'h3, 32'h5, 0, 1);
            tick();
            checks++;
            if ({flush, misalign, halted} !== 3'b000 || if_pc !== p + 32'h4) begin
                failures++;
                $display("FAIL not_taken%0d got f=%b m=%b h=%b pc=%h exp 0 0 0 pc=%h", i, flush, misalign, halted, if_pc, p + 32'h4);
            end
        end
    endtask

    task automatic test_wrap();
        jump_to(32'hFFFF_FFFC);
        idle();
        tick();
        checks++;
        if (if_pc !== 32'h0) begin
            failures++;
            $display("FAIL pc_wrap got %h exp 00000000", if_pc);
        end
    endtask

    task automatic test_jalr();
        drive(1, 1, 1, 32'h0, 32'h3, 32'h2001, 0, 1);
        tick();
        checks++;
        if ({if_pc, flush, misalign} !== {32'h2004, 2'b10}) begin
            failures++;
            $display("FAIL jalr_ok got pc=%h f=%b m=%b exp pc=00002004 f=1 m=0", if_pc, flush, misalign);
        end
        drive(1, 1, 1, 32'h0, 32'h1, 32'h2001, 0, 1);
        tick();
        checks++;
        if ({if_pc, flush, misalign, halted, if_valid} !== {32'h2004, 4'b1110}) begin
            failures++;
            $display("FAIL jalr_mis got pc=%h f=%b m=%b h=%b v=%b exp pc=00002004 1 1 1 0", if_pc, flush, misalign, halted, if_valid);
        end
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 0, 32'h0, 32'h40, 0, 0, 1);
            tick();
            checks++;
            if ({if_pc, flush, misalign, halted, if_valid} !== {32'h2004, 4'b0010}) begin
                failures++;
                $display("FAIL halt_hold%0d got pc=%h f=%b m=%b h=%b v=%b exp pc=00002004 0 0 1 0", i, if_pc, flush, misalign, halted, if_valid);
            end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        idle();
        tick();
        jump_to(32'h500);
        idle();
        checks++;
        if (flush !== 1'b1 || if_pc !== 32'h500) begin
            failures++;
            $display("FAIL ar_setup got f=%b pc=%h exp f=1 pc=00000500", flush, if_pc);
        end
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if ({if_valid, flush, misalign, halted, if_pc} !== 36'h0) begin
            failures++;
            $display("FAIL async_reset got v=%b f=%b m=%b h=%b pc=%h exp all zero", if_valid, flush, misalign, halted, if_pc);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (if_valid !== 1'b0) begin
            failures++;
            $display("FAIL ar_boot got v=%b exp 0", if_valid);
        end
        tick();
    endtask

    task automatic test_random();
        logic [31:0] imm, rs1;
        for (int i = 0; i < 400; i++) begin
            if (m_halt && $urandom_range(0, 3) == 0) do_reset();
            imm = 32'($signed(12'($urandom))) & 32'hFFFF_FFFC;
            if ($urandom_range(0, 7) == 0) imm = imm | 32'($urandom_range(1, 3));
            rs1 = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 3) == 0) rs1 = rs1 | 32'h1;
            drive($urandom_range(0, 3) == 0, 1'($urandom), 1'($urandom), $urandom & 32'hFFFF_FFFC,
                  imm, rs1, $urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0);
            checks++;
            if ({if_valid, flush, misalign, halted, if_pc} !== {exp_valid(), m_flush, m_mis, m_halt, m_pc}) begin
                failures++;
                $display("FAIL random%0d got v=%b f=%b m=%b h=%b pc=%h exp v=%b f=%b m=%b h=%b pc=%h",
                         i, if_valid, flush, misalign, halted, if_pc, exp_valid(), m_flush, m_mis, m_halt, m_pc);
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_redirect_acc();
        test_stall();
        test_not_taken();
        test_wrap();
        test_jalr();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
